// File: rtl/alu_p_stage.sv
// alu_p_stage: two-stage SIMD post-adder / logic unit feeding the P register.
// Stage 1 folds Z/W/X/Y (and the ONE48 correction carries) into carry-save
// sum/carry vectors; stage 2 resolves them with a lane-segmented adder.
// Optional pattern comparator is enabled by defining PATTERN_DETECT_EN; the
// 48-bit configuration chain holding PATTERN is always present.
module alu_p_stage #(
  parameter int precision_loss_width = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [47:0]                     W,
  input  logic [47:0]                     X,
  input  logic [47:0]                     Y,
  input  logic [47:0]                     Z,
  input  logic [precision_loss_width-1:0] M_SIMD_carry_Mux,
  input  logic [1:0]                      ALUMODE,
  input  logic [1:0]                      USE_SIMD,
  input  logic                            CARRYIN,
  input  logic                            CEP,
  input  logic                            in_valid,
  output logic [47:0]                     P,
  output logic [47:0]                     PCOUT,
  output logic [3:0]                      CARRYOUT,
  output logic                            out_valid,
  input  logic                            configuration_input,
  input  logic                            configuration_enable,
  output logic                            configuration_output,
  output logic                            PATTERNDETECT
);

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_XOR = 2'b10, ALU_AND = 2'b11} alu_op_e;
  typedef enum logic [1:0] {SIMD_ONE48 = 2'b00, SIMD_TWO24 = 2'b01, SIMD_FOUR12 = 2'b10} simd_e;
  typedef struct packed {
    logic [47:0] s;
    logic [47:0] c;
    logic [3:0]  k;
  } csa_t;

  localparam int MCW = (precision_loss_width < 16) ? precision_loss_width : 16;

  // Bit j set when 12-bit chunk j ends a lane (its bit 12j+11 is a lane MSB).
  function automatic logic [3:0] lane_tops(input simd_e m);
    case (m)
      SIMD_TWO24:  lane_tops = 4'b1010;
      SIMD_FOUR12: lane_tops = 4'b1111;
      default:     lane_tops = 4'b1000;
    endcase
  endfunction

  // 3:2 compressor whose carries never cross a lane boundary. A carry leaving a
  // lane MSB is recorded in k so the lane carry-out can be recovered exactly.
  function automatic csa_t csa3(input logic [47:0] a, input logic [47:0] b,
                                input logic [47:0] c, input logic [3:0] tops);
    logic [47:0] cy;
    csa_t        r;
    cy  = (a & b) | (a & c) | (b & c);
    r.s = a ^ b ^ c;
    r.c = {cy[46:0], 1'b0};
    for (int unsigned j = 0; j < 3; j++)
      if (tops[j]) r.c[12*j+12] = 1'b0;
    for (int unsigned j = 0; j < 4; j++)
      r.k[j] = cy[12*j+11] & tops[j];
    return r;
  endfunction

  simd_e       mode_d, s1_mode_q;
  alu_op_e     op_d, s1_op_q;
  logic [3:0]  tops_d, tops_s2;
  logic [47:0] zop, mc;
  csa_t        l1, l2, l3;
  logic [47:0] sum_d, cy_d, s1_sum_q, s1_cy_q;
  logic [3:0]  kp_d, s1_kp_q;
  logic        s1_valid_q;
  logic [47:0] p_d, p_q;
  logic [3:0]  co_d, co_q;
  logic        v2_q;
  logic [12:0] part;
  logic        chain;
  logic        arith_s2;
  logic [47:0] pattern_q;

  // Stage 1 combinational: operand conditioning and carry-save reduction.
  always_comb begin
    mode_d = (USE_SIMD == 2'b11) ? SIMD_ONE48 : simd_e'(USE_SIMD);
    op_d   = alu_op_e'(ALUMODE);
    tops_d = lane_tops(mode_d);
    zop    = (op_d == ALU_SUB) ? ~Z : Z;
    mc     = '0;
    if (mode_d == SIMD_ONE48) mc[32 +: MCW] = M_SIMD_carry_Mux[MCW-1:0];
    l1 = csa3(zop, W, X, tops_d);
    l2 = csa3(l1.s, l1.c, Y, tops_d);
    l3 = csa3(l2.s, l2.c, mc, tops_d);
    if (ALUMODE[1]) begin
      sum_d = (op_d == ALU_AND) ? (X & Z) : (X ^ Z);
      cy_d  = '0;
      kp_d  = '0;
    end else begin
      // Bit 0 of the carry vector is always free, so lane-0 carry-in lands there.
      sum_d = l3.s;
      cy_d  = l3.c | {47'b0, CARRYIN};
      kp_d  = l1.k ^ l2.k ^ l3.k;
    end
  end

  // Stage 1 registers: compressed vectors plus control, held while CEP is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum_q   <= '0;
      s1_cy_q    <= '0;
      s1_kp_q    <= '0;
      s1_mode_q  <= SIMD_ONE48;
      s1_op_q    <= ALU_ADD;
      s1_valid_q <= 1'b0;
    end else if (CEP) begin
      s1_sum_q   <= sum_d;
      s1_cy_q    <= cy_d;
      s1_kp_q    <= kp_d;
      s1_mode_q  <= mode_d;
      s1_op_q    <= op_d;
      s1_valid_q <= in_valid;
    end
  end

  // Stage 2 combinational: lane-segmented final add, subtract inversion, carries.
  always_comb begin
    tops_s2  = lane_tops(s1_mode_q);
    arith_s2 = (s1_op_q == ALU_ADD) || (s1_op_q == ALU_SUB);
    chain    = 1'b0;
    part     = '0;
    p_d      = '0;
    co_d     = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      part = {1'b0, s1_sum_q[12*j +: 12]} + {1'b0, s1_cy_q[12*j +: 12]} + {12'b0, chain};
      p_d[12*j +: 12] = part[11:0];
      // Lane carry = adder carry plus parity of carries dropped at this lane MSB.
      co_d[j] = arith_s2 & tops_s2[j] & (part[12] ^ s1_kp_q[j]);
      chain   = part[12] & ~tops_s2[j];
    end
    if (s1_op_q == ALU_SUB) p_d = ~p_d;
  end

  // Stage 2 registers: result, lane carries and output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q  <= '0;
      co_q <= '0;
      v2_q <= 1'b0;
    end else if (CEP) begin
      p_q  <= p_d;
      co_q <= co_d;
      v2_q <= s1_valid_q;
    end
  end

  // Configuration chain: 48-bit PATTERN shift register, independent of CEP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pattern_q <= '0;
    else if (configuration_enable) pattern_q <= {pattern_q[46:0], configuration_input};
  end

`ifdef PATTERN_DETECT_EN
  logic pd_q;

  // Pattern match registered alongside P.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pd_q <= 1'b0;
    else if (CEP) pd_q <= (p_d == pattern_q);
  end

  assign PATTERNDETECT = pd_q;
`else
  assign PATTERNDETECT = 1'b0;
`endif

  assign P                    = p_q;
  assign PCOUT                = p_q;
  assign CARRYOUT             = co_q;
  assign out_valid            = v2_q;
  assign configuration_output = pattern_q[47];

endmodule
